mac_2bit_stream_master: RTL and testbench

Initiator for the 2-bit MAC's AXI-Stream interface. It accepts a job command (bias, operand count, tag) plus a stream of 2-bit operand pairs into an internal FIFO. It emits the MAC input stream: one bias beat, then N operand beats, with TLAST on the final beat. It then collects the 32-bit MAC result and holds it for the host.

---
 rtl/mac_2bit_stream_master.sv | 198 +++++++++++++++++++
 tb/tb_mac_2bit_stream_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_2bit_stream_master.sv
// mac_2bit_stream_master
// Host-side initiator for the 2-bit MAC. It takes a job command and a stream
// of operand pairs, sends one bias beat and then LEN operand beats to the MAC
// over AXI-Stream, and holds the 32-bit result until the host takes it.
// Operands are buffered in a small FIFO that can be filled ahead of the command.
module mac_2bit_stream_master #(
    parameter int C_DATA_WIDTH = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // job command
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [2*C_DATA_WIDTH-1:0] CMD_BIAS,
    input  logic [LEN_WIDTH-1:0]      CMD_LEN,
    input  logic [31:0]               CMD_TAG,
    // operand pairs
    input  logic                      OP_VALID,
    output logic                      OP_READY,
    input  logic [C_DATA_WIDTH-1:0]   OP_A,
    input  logic [C_DATA_WIDTH-1:0]   OP_B,
    // stream toward the MAC
    output logic                      MO_AXIS_TVALID,
    input  logic                      MO_AXIS_TREADY,
    output logic [2*C_DATA_WIDTH-1:0] MO_AXIS_TDATA,
    output logic                      MO_AXIS_TLAST,
    output logic [31:0]               MO_AXIS_TUSER,
    // result stream from the MAC
    input  logic                      SD_AXIS_TVALID,
    output logic                      SD_AXIS_TREADY,
    input  logic [31:0]               SD_AXIS_TDATA,
    input  logic                      SD_AXIS_TLAST,
    // result toward the host
    output logic                      RES_VALID,
    input  logic                      RES_READY,
    output logic [31:0]               RES_DATA,
    output logic [31:0]               RES_TAG,
    output logic                      RES_ERR
);

    localparam int BEAT_W = 2 * C_DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_OPS,
        S_WAIT_RES,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // operand FIFO
    logic [BEAT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    // job context captured at command acceptance
    logic [BEAT_W-1:0]    bias_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] remaining_q;
    logic [31:0]          tag_q;

    logic cmd_fire, res_capture;

    assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign OP_READY   = !fifo_full;

    assign push        = OP_VALID && !fifo_full;
    // In OPS the beat is only offered while the FIFO holds data, so a pop
    // never underflows.
    assign pop         = (state == S_OPS) && !fifo_empty && MO_AXIS_TREADY;
    assign cmd_fire    = (state == S_IDLE) && CMD_VALID;
    assign res_capture = (state == S_WAIT_RES) && SD_AXIS_TVALID;

    // Operand storage: written on push, read combinationally at the head.
    // NOTE: the storage array is deliberately left without a reset; the count
    // and pointers define which entries are live, so stale words are never seen.
    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {OP_A, OP_B};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // State register.
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // update together from the values present before the edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job context: latch on command, count operand beats down to zero.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bias_q      <= '0;
            len_q       <= '0;
            tag_q       <= '0;
            remaining_q <= '0;
        end else if (cmd_fire) begin
            bias_q      <= CMD_BIAS;
            len_q       <= CMD_LEN;
            tag_q       <= CMD_TAG;
            remaining_q <= CMD_LEN;
        end else if (pop && (remaining_q != '0)) begin
            remaining_q <= remaining_q - LEN_WIDTH'(1);
        end
    end

    // Result capture: hold data, tag and framing error until the next job.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            RES_DATA <= '0;
            RES_TAG  <= '0;
            RES_ERR  <= 1'b0;
        end else if (res_capture) begin
            RES_DATA <= SD_AXIS_TDATA;
            RES_TAG  <= tag_q;
            RES_ERR  <= ~SD_AXIS_TLAST;
        end
    end

    // Next-state and handshake outputs for the job sequence.
    // NOTE: every output and the next state get a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        CMD_READY      = 1'b0;
        MO_AXIS_TVALID = 1'b0;
        MO_AXIS_TDATA  = '0;
        MO_AXIS_TLAST  = 1'b0;
        MO_AXIS_TUSER  = '0;
        SD_AXIS_TREADY = 1'b0;
        RES_VALID      = 1'b0;

        case (state)
            S_IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) state_nxt = S_BIAS;
            end
            S_BIAS: begin
                MO_AXIS_TVALID = 1'b1;
                MO_AXIS_TDATA  = bias_q;
                MO_AXIS_TLAST  = (len_q == '0);
                MO_AXIS_TUSER  = tag_q;
                if (MO_AXIS_TREADY) begin
                    state_nxt = (len_q == '0) ? S_WAIT_RES : S_OPS;
                end
            end
            S_OPS: begin
                // Head data only changes on a pop, so it stays stable while stalled.
                MO_AXIS_TVALID = !fifo_empty;
                MO_AXIS_TDATA  = fifo_mem[rd_ptr];
                MO_AXIS_TLAST  = (remaining_q == LEN_WIDTH'(1));
                MO_AXIS_TUSER  = tag_q;
                if (pop && (remaining_q == LEN_WIDTH'(1))) state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                SD_AXIS_TREADY = 1'b1;
                MO_AXIS_TUSER  = tag_q;
                if (SD_AXIS_TVALID) state_nxt = S_RESP;
            end
            S_RESP: begin
                RES_VALID     = 1'b1;
                MO_AXIS_TUSER = tag_q;
                if (RES_READY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_2bit_stream_master.sv
// Self-checking bench for mac_2bit_stream_master. The bench plays host, operand
// source and MAC; a job-level model (operand queue, beat index, running sum)
// predicts every handshake output, beat and result.
module tb_mac_2bit_stream_master;

    localparam int DEPTH = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [3:0]  CMD_BIAS;
    logic [7:0]  CMD_LEN;
    logic [31:0] CMD_TAG;
    logic        OP_VALID;
    logic        OP_READY;
    logic [1:0]  OP_A;
    logic [1:0]  OP_B;
    logic        MO_AXIS_TVALID;
    logic        MO_AXIS_TREADY;
    logic [3:0]  MO_AXIS_TDATA;
    logic        MO_AXIS_TLAST;
    logic [31:0] MO_AXIS_TUSER;
    logic        SD_AXIS_TVALID;
    logic        SD_AXIS_TREADY;
    logic [31:0] SD_AXIS_TDATA;
    logic        SD_AXIS_TLAST;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA;
    logic [31:0] RES_TAG;
    logic        RES_ERR;

    mac_2bit_stream_master #(
        .C_DATA_WIDTH(2),
        .FIFO_DEPTH  (DEPTH),
        .LEN_WIDTH   (8)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .CMD_VALID     (CMD_VALID),
        .CMD_READY     (CMD_READY),
        .CMD_BIAS      (CMD_BIAS),
        .CMD_LEN       (CMD_LEN),
        .CMD_TAG       (CMD_TAG),
        .OP_VALID      (OP_VALID),
        .OP_READY      (OP_READY),
        .OP_A          (OP_A),
        .OP_B          (OP_B),
        .MO_AXIS_TVALID(MO_AXIS_TVALID),
        .MO_AXIS_TREADY(MO_AXIS_TREADY),
        .MO_AXIS_TDATA (MO_AXIS_TDATA),
        .MO_AXIS_TLAST (MO_AXIS_TLAST),
        .MO_AXIS_TUSER (MO_AXIS_TUSER),
        .SD_AXIS_TVALID(SD_AXIS_TVALID),
        .SD_AXIS_TREADY(SD_AXIS_TREADY),
        .SD_AXIS_TDATA (SD_AXIS_TDATA),
        .SD_AXIS_TLAST (SD_AXIS_TLAST),
        .RES_VALID     (RES_VALID),
        .RES_READY     (RES_READY),
        .RES_DATA      (RES_DATA),
        .RES_TAG       (RES_TAG),
        .RES_ERR       (RES_ERR)
    );

    always #5 ACLK = ~ACLK;

    int vectors    = 0;
    int miscompares = 0;

    // Operands the bench still has to offer, and operands the DUT has accepted.
    logic [3:0]  to_push[$];
    logic [3:0]  fifo_model[$];
    logic [3:0]  seen_beats[$];
    logic [31:0] last_res_data;
    logic        last_res_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        CMD_VALID      = 1'b0;
        CMD_BIAS       = '0;
        CMD_LEN        = '0;
        CMD_TAG        = '0;
        OP_VALID       = 1'b0;
        OP_A           = '0;
        OP_B           = '0;
        MO_AXIS_TREADY = 1'b0;
        SD_AXIS_TVALID = 1'b0;
        SD_AXIS_TDATA  = '0;
        SD_AXIS_TLAST  = 1'b0;
        RES_READY      = 1'b0;
    endtask

    function automatic int prod(input logic [3:0] beat);
        logic signed [1:0] a, b;
        a = beat[3:2];
        b = beat[1:0];
        return int'(a) * int'(b);
    endfunction

    function automatic void fill_random(input int n);
        for (int i = 0; i < n; i++) to_push.push_back(4'($urandom_range(15)));
    endfunction

    // One job, cycle by cycle. Phases: 0 command, 1 beats, 2 await result,
    // 3 result held, 4 done. Called at a negedge with outputs settled.
    task automatic run_job(input logic [3:0] bias, input int len, input logic [31:0] tag,
                           input int pre_push, input int tready_mode, input int gap_pct,
                           input logic sd_last, input int hold, input int abort_at);
        int p = 0, p_now;
        int k = 0, pushed = 0, cyc = 0, held = 0, sd_delay = 0;
        int acc = 0, sent = 0;
        bit aborted = 0;
        logic prev_stall = 1'b0, prev_last = 1'b0;
        logic [3:0] prev_data = '0, op;
        logic signed [3:0] sbias;
        sbias = bias;
        seen_beats.delete();
        while (p != 4 && cyc < 2000 && !aborted) begin
            p_now = p;
            // expectations from the job model
            check("cmd_ready", CMD_READY, p_now == 0);
            check("sd_tready", SD_AXIS_TREADY, p_now == 2);
            check("res_valid", RES_VALID, p_now == 3);
            check("op_ready", OP_READY, fifo_model.size() < DEPTH);
            if (p_now == 1) begin
                check("tvalid_ops", MO_AXIS_TVALID, (k == 0) || (fifo_model.size() != 0));
                check("tuser", MO_AXIS_TUSER, tag);
            end else begin
                check("tvalid_idle", MO_AXIS_TVALID, 1'b0);
            end
            if (prev_stall) begin
                check("stall_tvalid", MO_AXIS_TVALID, 1'b1);
                check("stall_tdata", MO_AXIS_TDATA, prev_data);
                check("stall_tlast", MO_AXIS_TLAST, prev_last);
            end
            if (p_now == 1 && MO_AXIS_TVALID && (k == 0 || fifo_model.size() != 0)) begin
                check("tdata", MO_AXIS_TDATA, (k == 0) ? bias : fifo_model[0]);
                check("tlast", MO_AXIS_TLAST, k == len);
            end
            if (p_now == 3) begin
                check("res_data", RES_DATA, sent);
                check("res_tag", RES_TAG, tag);
                check("res_err", RES_ERR, !sd_last);
                last_res_data = RES_DATA;
                last_res_err  = RES_ERR;
            end

            // drive this cycle's inputs
            CMD_VALID = (p_now == 0) && (pushed >= pre_push);
            CMD_BIAS  = bias;
            CMD_LEN   = len[7:0];
            CMD_TAG   = tag;
            OP_VALID  = 1'b0;
            if (to_push.size() != 0 && (p_now == 0 || $urandom_range(99) >= gap_pct)) begin
                OP_VALID     = 1'b1;
                {OP_A, OP_B} = to_push[0];
            end
            case (tready_mode)
                0:       MO_AXIS_TREADY = 1'b1;
                1:       MO_AXIS_TREADY = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: MO_AXIS_TREADY = 1'($urandom_range(1));
            endcase
            SD_AXIS_TVALID = 1'b0;
            if (p_now == 2) begin
                if (sd_delay > 0) sd_delay--;
                else SD_AXIS_TVALID = 1'b1;
            end
            SD_AXIS_TDATA = acc;
            SD_AXIS_TLAST = sd_last;
            RES_READY     = (p_now == 3) && (held >= hold);
            if (p_now == 3) held++;

            // advance the model by the handshakes that happen at this edge
            if (p_now == 1 && MO_AXIS_TVALID && MO_AXIS_TREADY) begin
                seen_beats.push_back(MO_AXIS_TDATA);
                if (k == 0) begin
                    acc = int'(sbias);
                end else if (fifo_model.size() != 0) begin
                    op  = fifo_model.pop_front();
                    acc = acc + prod(op);
                end
                if (k == len) begin
                    p        = 2;
                    sd_delay = $urandom_range(2);
                end
                k++;
            end
            if (OP_VALID && OP_READY) begin
                fifo_model.push_back(to_push.pop_front());
                pushed++;
            end
            if (p_now == 0 && CMD_VALID && CMD_READY) p = 1;
            if (p_now == 2 && SD_AXIS_TVALID && SD_AXIS_TREADY) begin
                p    = 3;
                sent = acc;
            end
            if (p_now == 3 && RES_VALID && RES_READY) p = 4;
            prev_stall = MO_AXIS_TVALID && !MO_AXIS_TREADY;
            prev_data  = MO_AXIS_TDATA;
            prev_last  = MO_AXIS_TLAST;

            @(posedge ACLK);
            @(negedge ACLK);
            cyc++;
            if (abort_at > 0 && k >= abort_at) aborted = 1;
        end
        idle_inputs();
        if (aborted) begin
            ARESET = 1'b1;
            @(posedge ACLK);
            @(negedge ACLK);
            ARESET = 1'b0;
            fifo_model.delete();
            to_push.delete();
            check("abort_tvalid", MO_AXIS_TVALID, 1'b0);
            check("abort_cmd_ready", CMD_READY, 1'b1);
            check("abort_op_ready", OP_READY, 1'b1);
            check("abort_tdata", MO_AXIS_TDATA, 4'h0);
            check("abort_beats", seen_beats.size(), abort_at);
        end else begin
            check("job_done", p, 4);
            check("beat_count", seen_beats.size(), len + 1);
        end
    endtask

    initial begin
        logic [3:0] exp1 [4];
        logic [31:0] tag;
        int len;

        idle_inputs();
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_cmd_ready", CMD_READY, 1'b1);
        check("rst_op_ready", OP_READY, 1'b1);
        check("rst_tvalid", MO_AXIS_TVALID, 1'b0);
        check("rst_sd_tready", SD_AXIS_TREADY, 1'b0);
        check("rst_res_valid", RES_VALID, 1'b0);
        check("rst_tdata", MO_AXIS_TDATA, 4'h0);
        check("rst_tlast", MO_AXIS_TLAST, 1'b0);
        check("rst_tuser", MO_AXIS_TUSER, 32'h0);
        check("rst_res_data", RES_DATA, 32'h0);
        check("rst_res_tag", RES_TAG, 32'h0);
        check("rst_res_err", RES_ERR, 1'b0);
        ARESET = 1'b0;

        // Directed single job: beats 5,5,D,A and a result of 9.
        to_push.push_back(4'b0101);
        to_push.push_back(4'b1101);
        to_push.push_back(4'b1010);
        run_job(4'd5, 3, 32'hA5, 0, 0, 0, 1'b1, 0, 0);
        exp1 = '{4'h5, 4'h5, 4'hD, 4'hA};
        for (int i = 0; i < 4; i++)
            check("job1_beat", (i < seen_beats.size()) ? seen_beats[i] : 4'hx, exp1[i]);
        check("job1_res", last_res_data, 32'd9);
        check("job1_err", last_res_err, 1'b0);

        // Zero-length job: single bias beat with TLAST, result -1.
        run_job(4'hF, 0, 32'h1234_5678, 0, 0, 0, 1'b1, 0, 0);
        check("len0_beat", (seen_beats.size() != 0) ? seen_beats[0] : 4'hx, 4'hF);
        check("len0_res", last_res_data, 32'hFFFF_FFFF);

        // Backpressure with a 1,0,0,1 TREADY pattern.
        fill_random(6);
        run_job(4'($urandom_range(15)), 6, $urandom, 6, 1, 0, 1'b1, 0, 0);

        // FIFO filled to the brim before the command, remaining ops trickled in.
        fill_random(10);
        run_job(4'($urandom_range(15)), 10, $urandom, 8, 2, 70, 1'b1, 0, 0);

        // Result without TLAST, host holds off for 5 cycles.
        fill_random(2);
        run_job(4'($urandom_range(15)), 2, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 5, 0);
        check("err_flag", last_res_err, 1'b1);

        // Reset after the bias beat and one operand beat, then a fresh job.
        fill_random(4);
        run_job(4'h3, 4, 32'hC0DE, 4, 0, 0, 1'b1, 0, 2);
        fill_random(3);
        run_job(4'($urandom_range(15)), 3, 32'h5A5A, 0, 2, 20, 1'b1, 1, 0);

        // Random jobs.
        for (int j = 0; j < 12; j++) begin
            len = $urandom_range(12);
            tag = $urandom;
            fill_random(len);
            run_job(4'($urandom_range(15)), len, tag, $urandom_range((len < DEPTH) ? len : DEPTH),
                    $urandom_range(2), $urandom_range(60), 1'($urandom_range(1)),
                    $urandom_range(3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
